mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store unit for the pipeline MEM stage; sits directly upstream of the byte-addressed data memory and drives its ce/we/addr/data_i, consuming its combinational data_o.
- Accepts one RV32I load/store request per handshake; returns a registered, sign/zero-extended load result.
- The memory only writes full 4-byte words, so SB/SH run as a two-cycle read-modify-write sequenced by a small FSM; the unit stalls the pipeline meanwhile.
- Rejects out-of-range and malformed accesses without touching memory.

Parameters:
MEM_BYTES, 1024, number of addressable bytes; byte address a is legal iff a+3 < MEM_BYTES.
ADDR_W, 32, address width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept; =1 iff state==IDLE.
is_load  input  1  request is a load.
is_store  input  1  request is a store.
funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
addr  input  ADDR_W  byte address (already computed by EX).
wdata  input  32  store data (rs2).
resp_valid  output  1  one-cycle pulse: access complete.
resp_err  output  1  valid with resp_valid: access rejected.
load_data  output  32  extended load result, valid with resp_valid.
stall  output  1  = (req_valid & ~req_ready) | (state!=IDLE).
mem_ce  output  1  to memory ce.
mem_we  output  1  to memory we.
mem_addr  output  ADDR_W  to memory addr.
mem_wdata  output  32  to memory data_i.
mem_rdata  input  32  from memory data_o (combinational, little-endian from mem_addr).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; resp_valid=0, resp_err=0, load_data=0, merge register=0. mem_ce, mem_we and mem_addr are 0 whenever state==IDLE and no request is accepted.
- Accept: req_valid & req_ready & exactly one of is_load/is_store.
  - Neither flag set: no-op, no response.
  - Both flags set, or funct3 illegal for the op (loads: 011/110/111; stores: anything but 000/001/010): error response.
- Range check: addr+3 >= MEM_BYTES, computed with 33-bit arithmetic so wrap counts as out of range. Error response.
- Error response: mem_ce stays 0 in the accept cycle; next cycle resp_valid=1, resp_err=1, load_data=0.
- Load: accept cycle drives mem_ce=1, mem_we=0, mem_addr=addr. At the edge, register the extended mem_rdata. Next cycle resp_valid=1, resp_err=0. Latency 1, throughput 1 per cycle.
  - LB/LBU: bits [7:0], sign- or zero-extended.
  - LH/LHU: bits [15:0], sign- or zero-extended.
  - LW: all 32 bits.
  - Misaligned addresses are legal (memory is byte-addressed).
- SW: accept cycle drives mem_ce=1, mem_we=1, mem_addr=addr, mem_wdata=wdata. Write lands at the edge; next cycle resp_valid=1. Latency 1.
- SB/SH FSM: IDLE -> RMW_WRITE -> IDLE.
  - IDLE accept cycle: mem_ce=1, mem_we=0, mem_addr=addr. At the edge, latch merge register = {mem_rdata[31:8], wdata[7:0]} (SB) or {mem_rdata[31:16], wdata[15:0]} (SH), and latch addr.
  - RMW_WRITE: mem_ce=1, mem_we=1, mem_addr=latched addr, mem_wdata=merge register; req_ready=0.
  - Next cycle after RMW_WRITE: IDLE, resp_valid=1. Latency 2; one accept is lost.
- Inputs are ignored in RMW_WRITE; the requester holds them while stall=1.
- Reset asserted during RMW_WRITE: mem_we drops immediately, the write is abandoned (memory unchanged), and no resp_valid is produced.
- resp_valid is never high for two consecutive cycles from the same request.

Decomposition:
- Shared package: funct3 width codes (F3_B/H/W/BU/HU), FSM state encoding (IDLE, RMW_WRITE), MEM_BYTES default.
- One natural sub-module, load_extend: combinational (funct3, raw32) -> extended32. Reusable by writeback/forwarding.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 -> resp_valid 1 cycle after each accept; load_data=0xDEADBEEF, resp_err=0.
- SB wdata=0x12345655 @0x10 -> req_ready low exactly 1 cycle, resp_valid 2 cycles after accept; then LW @0x10 = 0xDEADBE55.
- LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x12 -> 0x0000DEAD.
- LW @0x3FE and SW @0xFFFFFFFF (MEM_BYTES=1024) -> mem_ce never asserted; resp_err=1, load_data=0; memory unchanged.
- is_load=is_store=1, or store funct3=100 -> error response, no memory access.
- SH 0xAAAA @0x10, rst_n pulsed low during RMW_WRITE -> no write (LW @0x10 still returns the pre-SH value), no resp_valid, req_ready=1 after reset.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: width codes, FSM states
// and the funct3 legality helpers used by the request decoder.
package mem_access_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MEM_BYTES_DEF = 1024;

    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Combinational load result extension: picks the low byte/half/word of a raw
// little-endian 32-bit read and sign- or zero-extends it according to funct3.
module mem_access_unit_load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-writing, byte-addressed memory;
// byte and halfword stores are done as a read-modify-write over two cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | ready for a request; loads, SW and errors complete from here
// RMW_WRITE | writing merged word for SB/SH; pipeline stalled
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       merge_q;

    logic              fire;
    logic              bad;
    logic              go;
    logic              is_rmw;
    logic              out_of_range;
    logic [ADDR_W:0]   last_byte;
    logic [31:0]       ext_data;

    // One extra bit so that addresses near the top of the space wrap into "illegal".
    assign last_byte    = {1'b0, addr} + (ADDR_W+1)'(3);
    assign out_of_range = last_byte >= (ADDR_W+1)'(MEM_BYTES);

    assign req_ready = (state == IDLE);
    assign stall     = (req_valid & ~req_ready) | (state != IDLE);
    assign fire      = req_valid & req_ready & (is_load | is_store);
    assign bad       = (is_load & is_store) |
                       (is_load & ~load_f3_ok(funct3)) |
                       (is_store & ~store_f3_ok(funct3)) |
                       out_of_range;
    assign go        = fire & ~bad;
    assign is_rmw    = is_store & ((funct3 == F3_B) | (funct3 == F3_H));

    mem_access_unit_load_extend u_load_extend (
        .funct3 (funct3),
        .raw    (mem_rdata),
        .ext    (ext_data)
    );

    always_comb begin
        mem_ce    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == RMW_WRITE) begin
            mem_ce    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = merge_q;
        end else if (go) begin
            mem_ce   = 1'b1;
            mem_addr = addr;
            if (is_store && !is_rmw) begin
                mem_we    = 1'b1;
                mem_wdata = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            merge_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            load_data  <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            load_data  <= '0;
                        end else if (is_load) begin
                            resp_valid <= 1'b1;
                            load_data  <= ext_data;
                        end else if (is_rmw) begin
                            state   <= RMW_WRITE;
                            addr_q  <= addr;
                            merge_q <= (funct3 == F3_B) ? {mem_rdata[31:8], wdata[7:0]}
                                                        : {mem_rdata[31:16], wdata[15:0]};
                        end else begin
                            resp_valid <= 1'b1;
                            load_data  <= '0;
                        end
                    end
                end
                RMW_WRITE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    load_data  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
